// File: rtl/sonar_ranger.sv
// Ultrasonic ranger sequencer: issues the sensor TRIG pulse, times the ECHO pulse and
// converts its width to millimetres with a prescaler instead of a divider.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for trigger with the echo line low
// TRIG      | driving trig_o high for TRIG_CYC cycles
// WAIT_RISE | waiting up to RISE_TIMEOUT cycles for the echo rising edge
// MEAS      | echo high: prescaler and distance accumulator running
// WAIT_LOW  | echo stuck high after timeout, waiting for it to drop
module sonar_ranger #(
    parameter int DisLen       = 16,
    parameter int TRIG_CYC     = 500,
    parameter int RISE_TIMEOUT = 100000,
    parameter int MAX_ECHO_CYC = 1900000,
    parameter int CYC_PER_UNIT = 291
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    output logic              triggerSuc,
    output logic              valid,
    output logic              fail,
    output logic [DisLen:0]   distance,
    output logic              trig_o,
    input  logic              echo_i
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEAS      = 3'd3;
    localparam logic [2:0] S_WAIT_LOW  = 3'd4;

    localparam int TMR_MAX = (RISE_TIMEOUT > TRIG_CYC) ? RISE_TIMEOUT : TRIG_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PRE_W   = $clog2(CYC_PER_UNIT + 1);
    localparam int ECHO_W  = 22;

    localparam logic [TMR_W-1:0]  TRIG_LOAD = TMR_W'(TRIG_CYC - 1);
    localparam logic [TMR_W-1:0]  RISE_LOAD = TMR_W'(RISE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYC_PER_UNIT - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = 1;
    localparam logic [ECHO_W-1:0] ECHO_LAST = ECHO_W'(MAX_ECHO_CYC - 1);
    localparam logic [ECHO_W-1:0] ECHO_ONE  = 1;
    localparam logic [DisLen:0]   DIST_MAX  = '1;
    localparam logic [DisLen:0]   DIST_ONE  = 1;

    logic              echo_q1;
    logic              echo_s;
    logic [2:0]        state;
    logic [TMR_W-1:0]  timer;
    logic [PRE_W-1:0]  prescale;
    logic [DisLen:0]   dist_acc;
    logic [ECHO_W-1:0] echo_cnt;

    logic [PRE_W-1:0]  prescale_inc;
    logic [DisLen:0]   dist_acc_inc;
    logic [ECHO_W-1:0] echo_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_q1 <= 1'b0;
            echo_s  <= 1'b0;
        end else begin
            echo_q1 <= echo_i;
            echo_s  <= echo_q1;
        end
    end

    // One echo-high cycle worth of counting; shared by the rising-edge cycle and MEAS.
    always_comb begin
        prescale_inc = prescale + PRE_ONE;
        dist_acc_inc = dist_acc;
        echo_cnt_inc = echo_cnt + ECHO_ONE;
        if (prescale == PRE_LAST) begin
            prescale_inc = '0;
            if (dist_acc != DIST_MAX) begin
                dist_acc_inc = dist_acc + DIST_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            prescale   <= '0;
            dist_acc   <= '0;
            echo_cnt   <= '0;
            trig_o     <= 1'b0;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            fail       <= 1'b0;
            distance   <= '0;
        end else begin
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            fail       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trigger && !echo_s) begin
                        state    <= S_TRIG;
                        trig_o   <= 1'b1;
                        timer    <= TRIG_LOAD;
                        prescale <= '0;
                        dist_acc <= '0;
                        echo_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    if (timer == '0) begin
                        trig_o     <= 1'b0;
                        triggerSuc <= 1'b1;
                        timer      <= RISE_LOAD;
                        state      <= S_WAIT_RISE;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                S_WAIT_RISE: begin
                    // The rising-edge cycle is already echo-high time, so it is counted here.
                    if (echo_s) begin
                        state    <= S_MEAS;
                        prescale <= prescale_inc;
                        dist_acc <= dist_acc_inc;
                        echo_cnt <= echo_cnt_inc;
                    end else if (timer == '0) begin
                        fail  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                S_MEAS: begin
                    if (!echo_s) begin
                        distance <= dist_acc;
                        valid    <= 1'b1;
                        state    <= S_IDLE;
                    end else if (echo_cnt >= ECHO_LAST) begin
                        fail  <= 1'b1;
                        state <= S_WAIT_LOW;
                    end else begin
                        prescale <= prescale_inc;
                        dist_acc <= dist_acc_inc;
                        echo_cnt <= echo_cnt_inc;
                    end
                end
                S_WAIT_LOW: begin
                    if (!echo_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    trig_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger, run with shortened timing parameters so every
// timeout and the distance saturation are reachable in a few thousand cycles.
module tb_sonar_ranger;

    localparam int DL  = 7;
    localparam int TC  = 20;
    localparam int RT  = 300;
    localparam int ME  = 2000;
    localparam int CPU = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic          echo_i;
    logic          triggerSuc;
    logic          valid;
    logic          fail;
    logic          trig_o;
    logic [DL:0]   distance;

    sonar_ranger #(
        .DisLen(DL), .TRIG_CYC(TC), .RISE_TIMEOUT(RT),
        .MAX_ECHO_CYC(ME), .CYC_PER_UNIT(CPU)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .triggerSuc(triggerSuc),
        .valid(valid), .fail(fail), .distance(distance), .trig_o(trig_o),
        .echo_i(echo_i)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_trig = 0, n_trise = 0, n_suc = 0, n_valid = 0, n_fail = 0, n_excl = 0;
    int   suc_cyc = 0, valid_cyc = 0, fail_cyc = 0, trig_rise_cyc = 0;
    logic prev_trig = 1'b0, prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (trig_o) n_trig++;
        if (trig_o && !prev_trig) begin
            n_trise++;
            trig_rise_cyc = cyc;
        end
        prev_trig = trig_o;
        if (triggerSuc) begin n_suc++;   suc_cyc   = cyc; end
        if (valid)      begin n_valid++; valid_cyc = cyc; end
        if (fail)       begin n_fail++;  fail_cyc  = cyc; end
        if ((int'(triggerSuc) + int'(valid) + int'(fail)) > 1 ||
            ((triggerSuc | valid | fail) && prev_pulse))
            n_excl++;
        prev_pulse = triggerSuc | valid | fail;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_of(input int sel);
        case (sel)
            0:       return n_trise;
            1:       return n_suc;
            2:       return n_valid;
            default: return n_fail;
        endcase
    endfunction

    task automatic wait_until(input int sel, input int target, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (count_of(sel) >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_reached"}, 32'(ok), 32'd1);
    endtask

    task automatic measure(input int width, input string tag);
        int s0, v0;
        s0 = n_suc;
        v0 = n_valid;
        @(posedge clk); #1; trigger = 1'b1;
        wait_until(1, s0 + 1, 100, {tag, "_suc"});
        @(posedge clk); #1; trigger = 1'b0;
        repeat (10) @(posedge clk);
        #1; echo_i = 1'b1;
        repeat (width) @(posedge clk);
        #1; echo_i = 1'b0;
        wait_until(2, v0 + 1, 20, {tag, "_valid"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, e0, f0, r0, s0, v0, fl0, tr0;

        rst_n = 1'b0; trigger = 1'b0; echo_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_trig_o",     32'(trig_o), 32'd0);
        check("rst_triggerSuc", 32'(triggerSuc), 32'd0);
        check("rst_valid",      32'(valid), 32'd0);
        check("rst_fail",       32'(fail), 32'd0);
        check("rst_distance",   32'(distance), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Nominal: trigger held high, 700 echo cycles -> 100 mm
        @(posedge clk); #1; t0 = cyc; trigger = 1'b1;
        wait_until(1, 1, 100, "nom_suc");
        check("nom_trig_width", 32'(n_trig), 32'd20);
        check("nom_trig_lat",   32'(trig_rise_cyc - t0), 32'd1);
        check("nom_suc_lat",    32'(suc_cyc - t0), 32'd21);
        check("nom_suc_count",  32'(n_suc), 32'd1);
        repeat (50) @(posedge clk);
        #1; e0 = cyc; echo_i = 1'b1;
        repeat (700) @(posedge clk);
        #1; f0 = cyc; echo_i = 1'b0;
        wait_until(2, 1, 20, "nom_valid");
        check("nom_distance",  32'(distance), 32'd100);
        check("nom_valid_lat", 32'(valid_cyc - f0), 32'd3);
        check("nom_no_fail",   32'(n_fail), 32'd0);

        // Trigger still high on return to IDLE starts a second TRIG
        wait_until(1, 2, 100, "retrig_suc");
        check("retrig_rise_lat", 32'(trig_rise_cyc - valid_cyc), 32'd1);
        check("retrig_trig_cyc", 32'(n_trig), 32'd40);
        @(posedge clk); #1; trigger = 1'b0;

        // Rounding: 6 cycles -> 0, 14 -> 2, 20 -> 2, 1900 saturates at 255
        repeat (10) @(posedge clk);
        #1; echo_i = 1'b1;
        repeat (6) @(posedge clk);
        #1; echo_i = 1'b0;
        wait_until(2, 2, 20, "rnd6_valid");
        check("rnd6_distance", 32'(distance), 32'd0);
        measure(14, "rnd14");
        check("rnd14_distance", 32'(distance), 32'd2);
        measure(20, "rnd20");
        check("rnd20_distance", 32'(distance), 32'd2);
        measure(1900, "sat");
        check("sat_distance", 32'(distance), 32'd255);

        // No echo: fail RT cycles after entering WAIT_RISE, distance kept
        fl0 = n_fail; s0 = n_suc;
        @(posedge clk); #1; trigger = 1'b1;
        wait_until(1, s0 + 1, 100, "noecho_suc");
        @(posedge clk); #1; trigger = 1'b0;
        wait_until(3, fl0 + 1, 400, "noecho_fail");
        check("noecho_fail_lat", 32'(fail_cyc - suc_cyc), 32'd300);
        check("noecho_distance", 32'(distance), 32'd255);
        measure(21, "after_noecho");
        check("after_noecho_distance", 32'(distance), 32'd3);

        // Stuck echo: fail after ME high cycles, trigger ignored until echo drops
        fl0 = n_fail; s0 = n_suc; v0 = n_valid;
        @(posedge clk); #1; trigger = 1'b1;
        wait_until(1, s0 + 1, 100, "stuck_suc");
        @(posedge clk); #1; trigger = 1'b0;
        repeat (10) @(posedge clk);
        #1; e0 = cyc; echo_i = 1'b1;
        wait_until(3, fl0 + 1, 2100, "stuck_fail");
        check("stuck_fail_lat", 32'(fail_cyc - e0), 32'd2002);
        check("stuck_distance", 32'(distance), 32'd3);
        tr0 = n_trise;
        @(posedge clk); #1; trigger = 1'b1;
        repeat (450) @(posedge clk);
        #1;
        check("stuck_trig_ignored", 32'(n_trise), 32'(tr0));
        check("stuck_no_valid",     32'(n_valid), 32'(v0));
        f0 = cyc; echo_i = 1'b0;
        wait_until(1, s0 + 2, 100, "stuck_retrig_suc");
        check("stuck_retrig_lat", 32'(trig_rise_cyc - f0), 32'd4);
        @(posedge clk); #1; trigger = 1'b0;
        wait_until(3, fl0 + 2, 400, "stuck_retrig_fail");
        check("stuck_retrig_fail_lat", 32'(fail_cyc - suc_cyc), 32'd300);

        // Stale echo: no TRIG while echo_s is high
        @(posedge clk); #1; echo_i = 1'b1;
        repeat (3) @(posedge clk);
        #1; trigger = 1'b1; tr0 = n_trise; r0 = n_trig; s0 = n_suc;
        repeat (60) @(posedge clk);
        #1;
        check("stale_no_trig", 32'(n_trise), 32'(tr0));
        f0 = cyc; echo_i = 1'b0;
        wait_until(1, s0 + 1, 100, "stale_suc");
        check("stale_rise_lat", 32'(trig_rise_cyc - f0), 32'd3);
        check("stale_trig_width", 32'(n_trig - r0), 32'd20);
        @(posedge clk); #1; trigger = 1'b0;
        repeat (10) @(posedge clk);
        #1; echo_i = 1'b1;
        repeat (35) @(posedge clk);
        #1; echo_i = 1'b0;
        wait_until(2, n_valid + 1, 20, "stale_valid");
        check("stale_distance", 32'(distance), 32'd5);

        // Reset in the middle of TRIG
        s0 = n_suc; v0 = n_valid; fl0 = n_fail; tr0 = n_trise;
        @(posedge clk); #1; trigger = 1'b1;
        wait_until(0, tr0 + 1, 10, "rstmid_trig");
        repeat (10) @(posedge clk);
        #1;
        check("rstmid_trig_high", 32'(trig_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_trig_drop", 32'(trig_o), 32'd0);
        trigger = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("rstmid_distance", 32'(distance), 32'd0);
        check("rstmid_no_suc",   32'(n_suc), 32'(s0));
        check("rstmid_no_valid", 32'(n_valid), 32'(v0));
        check("rstmid_no_fail",  32'(n_fail), 32'(fl0));

        check("pulse_exclusive", 32'(n_excl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_ranger.md
# sonar_ranger

Front-end sequencer for the HC-SR04-class ultrasonic sensor; it answers the cutter controller's `trigger` / `triggerSuc` / `valid` / `fail` / `distance` handshake. It generates the sensor TRIG pulse and times the ECHO pulse. It converts the echo width to millimetres without a divider and reports timeouts as `fail`. It sits between the top-level controller and the sensor GPIO pins, at 50 MHz.

## Interface
- `DisLen`, 16: distance output is `DisLen+1` bits.
- `TRIG_CYC`, 500: sensor TRIG high time in cycles (10 µs).
- `RISE_TIMEOUT`, 100000: maximum cycles to wait for the echo rising edge after TRIG (2 ms).
- `MAX_ECHO_CYC`, 1900000: maximum echo high time in cycles (38 ms).
- `CYC_PER_UNIT`, 291: echo cycles per 1 mm of distance.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `trigger`  in  1: measurement request from the controller; a level, sampled only in IDLE.
- `triggerSuc`  out  1: one-cycle pulse when the TRIG pulse has completed.
- `valid`  out  1: one-cycle pulse; `distance` is updated in the same cycle.
- `fail`  out  1: one-cycle pulse on echo-rise or echo-width timeout.
- `distance`  out  DisLen+1: last good distance in mm; held between `valid` pulses.
- `trig_o`  out  1: sensor TRIG pin.
- `echo_i`  in  1: sensor ECHO pin; asynchronous.

## Operation
- `echo_i` passes through a 2-FF synchronizer giving `echo_s`. All logic uses `echo_s` only.
- States:
  - IDLE.
  - TRIG.
  - WAIT_RISE.
  - MEAS.
  - WAIT_LOW.
- IDLE:
  - Moves to TRIG when `trigger`=1 and `echo_s`=0.
  - If `echo_s`=1, the request waits and no pulse is issued.
- TRIG: `trig_o`=1 for exactly TRIG_CYC cycles, then `triggerSuc` pulses, and the next state is WAIT_RISE.
- WAIT_RISE:
  - `echo_s`=1 moves to MEAS.
  - RISE_TIMEOUT cycles without a rise gives a `fail` pulse and a return to IDLE.
  - A rise on the timeout cycle wins (goes to MEAS, no fail).
- MEAS: a prescaler counts 0..CYC_PER_UNIT-1 on every cycle with `echo_s`=1.
  - On wrap, `dist_acc` increments.
  - `dist_acc` saturates at 2^(DisLen+1)-1.
  - `echo_cnt` (22 bits) counts the same cycles.
- MEAS end, first cycle with `echo_s`=0: `distance`<=`dist_acc`, `valid` pulses, next state IDLE.
  - This has priority over the echo timeout in the same cycle.
- MEAS timeout: `echo_cnt` reaching MAX_ECHO_CYC while `echo_s`=1 gives a `fail` pulse, next state WAIT_LOW, `distance` unchanged.
- WAIT_LOW: returns to IDLE when `echo_s`=0. `trigger` is ignored here.
- `trigger` is ignored outside IDLE.
  - The controller drops `trigger` one cycle after seeing `triggerSuc`; this causes no re-trigger.
  - A `trigger` still high on return to IDLE starts a new measurement. Inter-measurement spacing is the controller's job.
- Counters, prescaler and `dist_acc` clear on entry to TRIG.
- `valid`, `fail` and `triggerSuc` are mutually exclusive and never high on consecutive cycles from the same measurement.

## Timing
- Reset values:
  - `trig_o`=0.
  - `triggerSuc`=0.
  - `valid`=0.
  - `fail`=0.
  - `distance`=0.
  - State IDLE.
  - All counters 0.
  - Synchronizer FFs 0.
- Reset mid-operation: `trig_o` drops asynchronously with `rst_n`. The in-flight measurement is discarded and no `valid`/`fail` is issued.
- All outputs are registered.
- TRIG pulse timing, for `trigger` sampled high at edge k:
  - `trig_o` is high in cycles k+1..k+TRIG_CYC.
  - `trig_o` is low and `triggerSuc`=1 in cycle k+TRIG_CYC+1.
- Echo path latency: 2 cycles from `echo_i` to `echo_s`. MEAS is entered in the cycle after `echo_s` first reads 1.
- Distance result: for W cycles of `echo_s` high counted in MEAS, `distance` = min(floor(W/CYC_PER_UNIT), 2^(DisLen+1)-1).
  - `valid` is asserted 1 cycle after `echo_s` falls.
- Rise timeout: `fail` is asserted in the cycle after the RISE_TIMEOUT-th WAIT_RISE cycle.

## Test plan
- Nominal measurement:
  - Stimulus: `trigger` held high; `echo_i` rises 20000 cycles after `triggerSuc` and stays high 291×1000 cycles.
  - Required: exactly 500 `trig_o` cycles, one `triggerSuc`, one `valid` with `distance`=1000.
  - Required: `trigger` held high after return to IDLE starts a second TRIG.
- Rounding:
  - Stimulus: echo width 290 cycles, then width 582 cycles.
  - Required: `distance`=0, then `distance`=2.
- No echo:
  - Stimulus: `echo_i` never rises after TRIG.
  - Required: `fail` pulses 100000 cycles after entering WAIT_RISE; `distance` keeps its previous value.
  - Required: the next `trigger` issues a new TRIG.
- Stuck echo:
  - Stimulus: echo held high for 2500000 cycles.
  - Required: `fail` after 1900000 high cycles; the block waits in WAIT_LOW; a `trigger` asserted while the echo is still high is ignored; a `trigger` after the echo falls is accepted.
- Stale echo:
  - Stimulus: `echo_i` high while idle, with `trigger` asserted.
  - Required: no `trig_o` until `echo_s` low; then a normal 500-cycle pulse.
- Reset mid-TRIG:
  - Stimulus: `rst_n` low at TRIG cycle 200.
  - Required: `trig_o` low immediately; no `triggerSuc`, `valid` or `fail`; `distance`=0 after release.
